// File: rtl/sobel_window_gen_pkg.sv
// Shared sobel constants, default geometry, window row type and pixel zero-extension.
package sobel_window_gen_pkg;

   localparam int SOBEL_PIX_W = 8;
   localparam int SOBEL_OPD_W = 9;
   localparam int SOBEL_IMG_W = 64;
   localparam int SOBEL_IMG_H = 48;

   typedef logic [SOBEL_OPD_W-1:0] sobel_opd_t;

   // One row of the 3x3 window, left in the MSBs so a left shift is a plain concatenation.
   typedef struct packed {
      sobel_opd_t l;
      sobel_opd_t c;
      sobel_opd_t r;
   } sobel_row_t;

   function automatic sobel_opd_t sobel_zext(input sobel_opd_t pix, input int pix_w);
      logic [SOBEL_OPD_W:0] mask;
      mask = (10'd1 << pix_w) - 10'd1;
      return pix & mask[SOBEL_OPD_W-1:0];
   endfunction

endpackage

// File: rtl/sobel_window_gen_if.sv
// Pixel-in / window-out bundle of sobel_window_gen. SOBEL_WIN_SOF_EN adds sof_in.
interface sobel_window_gen_if
   import sobel_window_gen_pkg::*;
   #(parameter int PIX_W = SOBEL_PIX_W);

   logic [PIX_W-1:0] pix_in;
   logic             pix_valid;
`ifdef SOBEL_WIN_SOF_EN
   logic             sof_in;
`endif
   sobel_opd_t       p0, p1, p2, p3, p5, p6, p7, p8;
   logic             win_valid;
   logic             frame_done;

`ifdef SOBEL_WIN_SOF_EN
   modport master (output pix_in, pix_valid, sof_in,
                   input  p0, p1, p2, p3, p5, p6, p7, p8, win_valid, frame_done);
   modport slave  (input  pix_in, pix_valid, sof_in,
                   output p0, p1, p2, p3, p5, p6, p7, p8, win_valid, frame_done);
`else
   modport master (output pix_in, pix_valid,
                   input  p0, p1, p2, p3, p5, p6, p7, p8, win_valid, frame_done);
   modport slave  (input  pix_in, pix_valid,
                   output p0, p1, p2, p3, p5, p6, p7, p8, win_valid, frame_done);
`endif

endinterface

// File: rtl/sobel_line_buf.sv
// One image line of storage: combinational read, write on clk, same address (read-before-write).
module sobel_line_buf #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);

   // Deliberately not reset: stale lines are hidden by the border mask downstream.
   logic [WIDTH-1:0] mem [DEPTH];

   assign rdata = mem[addr];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 neighbourhood generator for sobel; two chained line buffers plus a 3x3 shift window.
// Optional SOBEL_WIN_SOF_EN: sof_in forces the accepted pixel to position (0,0).
module sobel_window_gen
   import sobel_window_gen_pkg::*;
#(
   parameter int IMG_W = SOBEL_IMG_W,
   parameter int IMG_H = SOBEL_IMG_H,
   parameter int PIX_W = SOBEL_PIX_W
) (
   input logic clk,
   input logic rst,
   sobel_window_gen_if.slave bus
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [CW-1:0] COL_MIN  = CW'(2);
   localparam logic [RW-1:0] ROW_MIN  = RW'(2);

   logic [CW-1:0]    col, pos_col;
   logic [RW-1:0]    row, pos_row;
   logic [PIX_W-1:0] lb0_q, lb1_q;
   sobel_row_t       top, mid, bot;
   logic             win_valid, frame_done;
   logic             col_last, row_last;

   // Position of the pixel being accepted this cycle.
   always_comb begin
      pos_col = col;
      pos_row = row;
`ifdef SOBEL_WIN_SOF_EN
      if (bus.sof_in) begin
         pos_col = '0;
         pos_row = '0;
      end
`endif
   end

   assign col_last = (pos_col == COL_LAST);
   assign row_last = (pos_row == ROW_LAST);

   sobel_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(CW)) u_lb0 (
      .clk   (clk),
      .we    (bus.pix_valid),
      .addr  (pos_col),
      .wdata (bus.pix_in),
      .rdata (lb0_q)
   );

   sobel_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(CW)) u_lb1 (
      .clk   (clk),
      .we    (bus.pix_valid),
      .addr  (pos_col),
      .wdata (lb0_q),
      .rdata (lb1_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         col        <= '0;
         row        <= '0;
         top        <= '0;
         mid        <= '0;
         bot        <= '0;
         win_valid  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         win_valid  <= 1'b0;
         frame_done <= 1'b0;
         if (bus.pix_valid) begin
            top <= {top.c, top.r, sobel_zext(sobel_opd_t'(lb1_q), PIX_W)};
            mid <= {mid.c, mid.r, sobel_zext(sobel_opd_t'(lb0_q), PIX_W)};
            bot <= {bot.c, bot.r, sobel_zext(sobel_opd_t'(bus.pix_in), PIX_W)};
            // Windows straddling a row wrap or the top two lines are masked here.
            win_valid  <= (pos_row >= ROW_MIN) && (pos_col >= COL_MIN);
            frame_done <= row_last && col_last;
            col        <= col_last ? '0 : pos_col + 1'b1;
            if (col_last) row <= row_last ? '0 : pos_row + 1'b1;
            else          row <= pos_row;
         end
      end
   end

   assign bus.p0         = top.l;
   assign bus.p1         = top.c;
   assign bus.p2         = top.r;
   assign bus.p3         = mid.l;
   assign bus.p5         = mid.r;
   assign bus.p6         = bot.l;
   assign bus.p7         = bot.c;
   assign bus.p8         = bot.r;
   assign bus.win_valid  = win_valid;
   assign bus.frame_done = frame_done;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Randomized self-checking bench for sobel_window_gen (IMG_W=8, IMG_H=6) against a frame-array model.
module tb_sobel_window_gen;

   localparam int W = 8;
   localparam int H = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sobel_window_gen_if #(.PIX_W(8)) bus ();

   sobel_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Neighbour offsets relative to the newest pixel (r,c), in p0,p1,p2,p3,p5,p6,p7,p8 order.
   int DR[8] = '{-2, -2, -2, -1, -1, 0, 0, 0};
   int DC[8] = '{-2, -1, 0, -2, 0, -2, -1, 0};
   string PN[8] = '{"p0", "p1", "p2", "p3", "p5", "p6", "p7", "p8"};

   int  vec_cnt = 0;
   int  err_cnt = 0;
   int  img [H][W];
   int  ep [8];
   int  mr, mc;
   bit  known, ewv, efd;
   int  nwin, nfd, fw_p0, fw_p8, fd_p8, fd_wv;

   task automatic chk(input string tag, input int got, input int exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic int get_p(input int k);
      case (k)
         0: return int'(bus.p0);
         1: return int'(bus.p1);
         2: return int'(bus.p2);
         3: return int'(bus.p3);
         4: return int'(bus.p5);
         5: return int'(bus.p6);
         6: return int'(bus.p7);
         default: return int'(bus.p8);
      endcase
   endfunction

   task automatic cycle(input bit vld, input int v, input bit sof);
      bus.pix_valid = vld;
      bus.pix_in    = 8'(v);
`ifdef SOBEL_WIN_SOF_EN
      bus.sof_in    = sof;
`endif
      ewv = 1'b0;
      efd = 1'b0;
      if (vld) begin
         if (sof) begin mr = 0; mc = 0; end
         img[mr][mc] = v & 255;
         ewv   = (mr >= 2) && (mc >= 2);
         efd   = (mr == H-1) && (mc == W-1);
         known = ewv;
         if (ewv) for (int k = 0; k < 8; k++) ep[k] = img[mr+DR[k]][mc+DC[k]];
         mc++;
         if (mc == W) begin mc = 0; mr = (mr + 1) % H; end
      end
      @(posedge clk); #1;
      chk("win_valid", int'(bus.win_valid), int'(ewv));
      chk("frame_done", int'(bus.frame_done), int'(efd));
      if (known) for (int k = 0; k < 8; k++) chk(PN[k], get_p(k), ep[k]);
      if (bus.win_valid) begin
         nwin++;
         if (fw_p0 < 0) begin fw_p0 = int'(bus.p0); fw_p8 = int'(bus.p8); end
      end
      if (bus.frame_done) begin
         nfd++;
         fd_p8 = int'(bus.p8);
         fd_wv = int'(bus.win_valid);
      end
      bus.pix_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.pix_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      mr = 0; mc = 0; known = 1'b1;
      for (int k = 0; k < 8; k++) ep[k] = 0;
      chk("rst_win_valid", int'(bus.win_valid), 0);
      chk("rst_frame_done", int'(bus.frame_done), 0);
      for (int k = 0; k < 8; k++) chk({"rst_", PN[k]}, get_p(k), 0);
   endtask

   task automatic clr_stats();
      nwin = 0; nfd = 0; fw_p0 = -1; fw_p8 = -1; fd_p8 = -1; fd_wv = -1;
   endtask

   task automatic run_frame(input int base, input bit rnd, input int max_gap);
      int v;
      clr_stats();
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            v = rnd ? int'($urandom_range(0, 255)) : base + r*16 + c;
            cycle(1'b1, v, 1'b0);
            repeat ($urandom_range(0, max_gap)) cycle(1'b0, 0, 1'b0);
         end
   endtask

   task automatic chk_plain_frame(input string s, input int base);
      chk({s, "_nwin"}, nwin, 24);
      chk({s, "_nfd"}, nfd, 1);
      chk({s, "_first_p0"}, fw_p0, base);
      chk({s, "_first_p8"}, fw_p8, base + 'h22);
      chk({s, "_last_p8"}, fd_p8, base + 'h57);
      chk({s, "_fd_with_win"}, fd_wv, 1);
   endtask

   initial begin
      bus.pix_valid = 1'b0;
      bus.pix_in    = '0;
`ifdef SOBEL_WIN_SOF_EN
      bus.sof_in    = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      run_frame(0, 1'b0, 0);
      chk_plain_frame("cont", 0);

      run_frame(0, 1'b0, 3);
      chk_plain_frame("gaps", 0);

      run_frame(0, 1'b0, 0);
      chk_plain_frame("b2b_a", 0);
      run_frame('h80, 1'b0, 1);
      chk_plain_frame("b2b_b", 'h80);

      // Abort mid-frame right after pixel (3,4), then restart.
      for (int i = 0; i <= 3*W + 4; i++) cycle(1'b1, (i / W) * 16 + (i % W), 1'b0);
      do_reset();
      run_frame(0, 1'b0, 2);
      chk_plain_frame("rst_mid", 0);

      run_frame(0, 1'b1, 3);
      chk("rand_nwin", nwin, 24);
      chk("rand_nfd", nfd, 1);

`ifdef SOBEL_WIN_SOF_EN
      // Truncate frame 1 at (4,5): that pixel becomes (0,0) of frame 2.
      clr_stats();
      for (int i = 0; i < 4*W + 5; i++) cycle(1'b1, (i / W) * 16 + (i % W), 1'b0);
      cycle(1'b1, 0, 1'b1);
      for (int i = 1; i < W*H; i++) begin
         cycle(1'b1, (i / W) * 16 + (i % W), 1'b0);
         repeat ($urandom_range(0, 1)) cycle(1'b0, 0, 1'b0);
      end
      chk("sof_nfd", nfd, 1);
      chk("sof_nwin", nwin, 15 + 24);
      chk("sof_last_p8", fd_p8, 'h57);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
